// File: rtl/bot_arena_if.sv
// Motor / light-sensor bus between a scoot-bot and its environment.
// The bot drives the four motor commands; the arena drives the four
// light-sensor lines back.
interface bot_arena_if;
  logic mUp;
  logic mRight;
  logic mDown;
  logic mLeft;
  logic lUp;
  logic lRight;
  logic lDown;
  logic lLeft;

  // Bot side: issues motor commands, reads sensors.
  modport master (
    output mUp, mRight, mDown, mLeft,
    input  lUp, lRight, lDown, lLeft
  );

  // Arena side: reads motor commands, drives sensors.
  modport slave (
    input  mUp, mRight, mDown, mLeft,
    output lUp, lRight, lDown, lLeft
  );
endinterface

// File: rtl/bot_arena.sv
// Environment model for a scoot-bot: moves a virtual bot on a square grid
// at a fixed tick rate according to its motor commands, drives the
// light-sensor lines back, and reports position, step count, wall bumps
// and arrival at the light for fitness scoring.
module bot_arena #(
  parameter int COORD_W     = 4,
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int LIGHT_X     = 8,
  parameter int LIGHT_Y     = 8,
  parameter int MOVE_PERIOD = 4
) (
  input  logic               clk,
  input  logic               reset,
  bot_arena_if.slave         bot,
  input  logic               lightLoad,
  input  logic [COORD_W-1:0] lightXIn,
  input  logic [COORD_W-1:0] lightYIn,
  output logic [COORD_W-1:0] posX,
  output logic [COORD_W-1:0] posY,
  output logic [15:0]        stepCount,
  output logic               bump,
  output logic               arrived
);

  localparam int                 TW        = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(MOVE_PERIOD - 1);
  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [COORD_W-1:0] START_XC  = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC  = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] LIGHT_XC  = COORD_W'(LIGHT_X);
  localparam logic [COORD_W-1:0] LIGHT_YC  = COORD_W'(LIGHT_Y);

  // Result of trying to move one axis by one cell.
  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic               blocked;
  } axis_t;

  // Sensor lines bundled as {up, right, down, left}.
  typedef struct packed {
    logic up;
    logic right;
    logic down;
    logic left;
  } sense_t;

  // Opposing commands cancel; a move off the grid is suppressed and flagged.
  function automatic axis_t axis_move(input logic [COORD_W-1:0] p,
                                      input logic inc, input logic dec);
    axis_t r;
    r.pos     = p;
    r.blocked = 1'b0;
    if (inc && !dec) begin
      if (p == COORD_MAX) r.blocked = 1'b1;
      else                r.pos     = p + 1'b1;
    end else if (dec && !inc) begin
      if (p == '0) r.blocked = 1'b1;
      else         r.pos     = p - 1'b1;
    end
    return r;
  endfunction

  logic [TW-1:0]      timer_q, timer_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [COORD_W-1:0] light_x_q, light_x_d;
  logic [COORD_W-1:0] light_y_q, light_y_d;
  logic [15:0]        step_q, step_d;
  logic               blocked_q, blocked_d;
  logic               bump_q, bump_d;
  logic               arrived_q, arrived_d;
  sense_t             sense_q, sense_d;

  logic  tick;
  axis_t ax, ay;

  assign tick = (timer_q == TICK_LAST);

  // Next-state: tick timer, movement, step count, bump pipeline, arrival,
  // light load and sensor comparison.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through this block leaves a value unassigned and infers a latch.
    timer_d   = tick ? '0 : timer_q + 1'b1;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    light_x_d = light_x_q;
    light_y_d = light_y_q;
    step_d    = step_q;
    blocked_d = 1'b0;
    arrived_d = arrived_q;

    ax = axis_move(pos_x_q, bot.mRight, bot.mLeft);
    ay = axis_move(pos_y_q, bot.mUp, bot.mDown);

    // Motors only matter on a tick, and only while not yet arrived
    // (the registered arrival, even if a light load clears it this cycle).
    if (tick && !arrived_q) begin
      pos_x_d   = ax.pos;
      pos_y_d   = ay.pos;
      blocked_d = ax.blocked | ay.blocked;
      if (((ax.pos != pos_x_q) || (ay.pos != pos_y_q)) && (step_q != 16'hFFFF))
        step_d = step_q + 16'd1;
    end

    // bump trails the blocked tick by one cycle so it lines up with the
    // sensors and arrival flag that reflect the post-tick position.
    bump_d = blocked_q;

    if (lightLoad) begin
      light_x_d = lightXIn;
      light_y_d = lightYIn;
      arrived_d = 1'b0;
    end else if ((pos_x_q == light_x_q) && (pos_y_q == light_y_q)) begin
      arrived_d = 1'b1;
    end

    sense_d.up    = light_y_q > pos_y_q;
    sense_d.down  = light_y_q < pos_y_q;
    sense_d.right = light_x_q > pos_x_q;
    sense_d.left  = light_x_q < pos_x_q;
  end

  // State registers with synchronous reset that overrides all inputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      timer_q   <= '0;
      pos_x_q   <= START_XC;
      pos_y_q   <= START_YC;
      light_x_q <= LIGHT_XC;
      light_y_q <= LIGHT_YC;
      step_q    <= '0;
      blocked_q <= 1'b0;
      bump_q    <= 1'b0;
      arrived_q <= 1'b0;
      sense_q   <= '0;
    end else begin
      timer_q   <= timer_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      light_x_q <= light_x_d;
      light_y_q <= light_y_d;
      step_q    <= step_d;
      blocked_q <= blocked_d;
      bump_q    <= bump_d;
      arrived_q <= arrived_d;
      sense_q   <= sense_d;
    end
  end

  assign posX       = pos_x_q;
  assign posY       = pos_y_q;
  assign stepCount  = step_q;
  assign bump       = bump_q;
  assign arrived    = arrived_q;
  assign bot.lUp    = sense_q.up;
  assign bot.lRight = sense_q.right;
  assign bot.lDown  = sense_q.down;
  assign bot.lLeft  = sense_q.left;

endmodule

// File: tb/tb_bot_arena.sv
// Self-checking bench for bot_arena: a cycle-level behavioural model of the
// grid world is compared against the DUT on every cycle, and a directed
// scenario (reset, approach and arrival, light reload, diagonal and wall
// bumps, corner pinning, mid-move reset) is pinned with literal values.
module tb_bot_arena;

  localparam int W     = 4;
  localparam int SX    = 3;
  localparam int SY    = 5;
  localparam int LX    = 8;
  localparam int LY    = 8;
  localparam int P     = 4;
  localparam int CMAX  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         lightLoad;
  logic [W-1:0] lightXIn, lightYIn;
  logic [W-1:0] posX, posY;
  logic [15:0]  stepCount;
  logic         bump, arrived;

  bot_arena_if bus ();

  bot_arena #(
    .COORD_W(W), .START_X(SX), .START_Y(SY),
    .LIGHT_X(LX), .LIGHT_Y(LY), .MOVE_PERIOD(P)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .bot       (bus),
    .lightLoad (lightLoad),
    .lightXIn  (lightXIn),
    .lightYIn  (lightYIn),
    .posX      (posX),
    .posY      (posY),
    .stepCount (stepCount),
    .bump      (bump),
    .arrived   (arrived)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid = 0;
  int m_x, m_y, m_lx, m_ly, m_steps, m_cycle;
  bit m_arr, m_blk, m_bump, m_lu, m_lr, m_ld, m_ll;
  int ox, oy, olx, oly, nx, ny;
  bit oarr, is_tick, moved_blk;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_x = SX; m_y = SY; m_lx = LX; m_ly = LY;
      m_steps = 0; m_cycle = 0;
      m_arr = 0; m_blk = 0; m_bump = 0;
      {m_lu, m_lr, m_ld, m_ll} = 4'b0000;
    end else if (m_valid) begin
      ox = m_x; oy = m_y; olx = m_lx; oly = m_ly; oarr = m_arr;
      m_lu = oly > oy; m_ld = oly < oy;
      m_lr = olx > ox; m_ll = olx < ox;
      is_tick = (m_cycle % P) == P - 1;
      m_cycle++;
      m_bump = m_blk;
      m_blk  = 0;
      if (is_tick && !oarr) begin
        nx = ox + int'(bus.mRight) - int'(bus.mLeft);
        ny = oy + int'(bus.mUp) - int'(bus.mDown);
        moved_blk = 0;
        if (nx < 0 || nx > CMAX) moved_blk = 1; else m_x = nx;
        if (ny < 0 || ny > CMAX) moved_blk = 1; else m_y = ny;
        m_blk = moved_blk;
        if ((m_x != ox || m_y != oy) && m_steps < 65535) m_steps++;
      end
      if (lightLoad) begin
        m_arr = 0;
        m_lx = lightXIn; m_ly = lightYIn;
      end else if (ox == olx && oy == oly) begin
        m_arr = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("posX", posX, m_x);
      check("posY", posY, m_y);
      check("stepCount", stepCount, m_steps);
      check("bump", bump, m_bump);
      check("arrived", arrived, m_arr);
      check("lUp", bus.lUp, m_lu);
      check("lRight", bus.lRight, m_lr);
      check("lDown", bus.lDown, m_ld);
      check("lLeft", bus.lLeft, m_ll);
    end
  end

  // Edges counted since the last reset edge (reset edge itself is 0).
  int edge_n = 0;
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic at_edge(input int k);
    while (edge_n < k) @(negedge clk);
  endtask

  task automatic motors(input bit up, input bit right, input bit down, input bit left);
    bus.mUp = up; bus.mRight = right; bus.mDown = down; bus.mLeft = left;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    lightLoad = 1'b0; lightXIn = '0; lightYIn = '0;
    motors(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;                               // edge 0 was the release edge

    // Load light (5,2) and head down-left toward (2,2).
    lightLoad = 1'b1; lightXIn = 4'd5; lightYIn = 4'd2;
    motors(0, 0, 1, 1);
    at_edge(1);
    lightLoad = 1'b0;
    check("rst_posX", posX, 3);
    check("rst_posY", posY, 5);
    check("rst_lUp", bus.lUp, 1);
    check("rst_lRight", bus.lRight, 1);
    check("rst_lDown", bus.lDown, 0);
    check("rst_lLeft", bus.lLeft, 0);
    check("rst_steps", stepCount, 0);
    check("rst_arrived", arrived, 0);
    at_edge(3);
    check("pre_tick_posX", posX, 3);
    at_edge(4);
    check("diag_posX", posX, 2);
    check("diag_posY", posY, 4);
    motors(0, 0, 1, 0);
    at_edge(12);
    check("down_posY", posY, 2);
    motors(0, 1, 0, 0);
    at_edge(16); check("right1_posX", posX, 3);
    at_edge(20); check("right2_posX", posX, 4);
    at_edge(24); check("right3_posX", posX, 5);
    check("approach_steps", stepCount, 6);
    at_edge(25);
    check("arrive_flag", arrived, 1);
    check("arrive_sense", {bus.lUp, bus.lRight, bus.lDown, bus.lLeft}, 0);
    at_edge(40);
    check("hold_posX", posX, 5);
    check("hold_steps", stepCount, 6);

    // Reload light at (5,6) and move up to it.
    lightLoad = 1'b1; lightXIn = 4'd5; lightYIn = 4'd6;
    motors(1, 0, 0, 0);
    at_edge(41);
    lightLoad = 1'b0;
    check("reload_arrived", arrived, 0);
    at_edge(42);
    check("reload_lUp", bus.lUp, 1);
    at_edge(56);
    check("up_posY", posY, 6);
    at_edge(57);
    check("up_arrived", arrived, 1);
    check("up_steps", stepCount, 10);

    // Light far away; up+down cancel while moving right into the wall.
    lightLoad = 1'b1; lightXIn = 4'd15; lightYIn = 4'd15;
    motors(1, 1, 1, 0);
    at_edge(58);
    lightLoad = 1'b0;
    at_edge(60);
    check("cancel_posX", posX, 6);
    check("cancel_posY", posY, 6);
    check("cancel_steps", stepCount, 11);
    at_edge(61);
    check("cancel_bump", bump, 0);
    at_edge(100);
    check("wall_posX", posX, 15);
    check("wall_bump_early", bump, 0);
    at_edge(101);
    check("wall_bump", bump, 1);
    at_edge(102);
    check("wall_bump_end", bump, 0);
    check("wall_steps", stepCount, 20);

    // Pin into the (0,0) corner.
    motors(0, 0, 1, 1);
    at_edge(160);
    check("corner_posX", posX, 0);
    check("corner_posY", posY, 0);
    at_edge(165); check("corner_bump1", bump, 1);
    at_edge(166); check("corner_bump_gap", bump, 0);
    at_edge(169); check("corner_bump2", bump, 1);
    at_edge(170); check("corner_steps", stepCount, 35);

    // Walk to (7,3), then reset mid-move.
    motors(1, 1, 0, 0);
    at_edge(180);
    motors(0, 1, 0, 0);
    at_edge(196);
    check("pre_reset_posX", posX, 7);
    check("pre_reset_posY", posY, 3);
    at_edge(197);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_posX", posX, 3);
    check("mid_rst_posY", posY, 5);
    check("mid_rst_steps", stepCount, 0);
    check("mid_rst_bump", bump, 0);
    at_edge(3);
    check("post_rst_pre_tick", posX, 3);
    at_edge(4);
    check("post_rst_tick", posX, 4);
    check("post_rst_steps", stepCount, 1);
    at_edge(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
